// File: rtl/sram_cache_ctrl_if.sv
// sram_cache_ctrl_if: word-request channel between the MEM stage and the
// SRAM cache controller.
//
// Handshake: the MEM stage raises MEM_R_EN or MEM_W_EN with address and
// writeData, and holds all of them stable while SRAM_NOT_READY=1. A request
// completes in the first cycle in which an enable is high and
// SRAM_NOT_READY=0; readData is meaningful in that cycle only.
//
// Signals:
//   MEM_R_EN, MEM_W_EN  request enables (write wins if both are high)
//   address             byte address, word index = address[15:2]
//   writeData           store data
//   readData            load data
//   SRAM_NOT_READY      pipeline freeze while the request is outstanding
interface sram_cache_ctrl_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [15:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        SRAM_NOT_READY;

    modport master (
        output MEM_R_EN, MEM_W_EN, address, writeData,
        input  readData, SRAM_NOT_READY
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, writeData,
        output readData, SRAM_NOT_READY
    );
endinterface

// File: rtl/sram_cache_ctrl.sv
// sram_cache_ctrl: direct-mapped read cache in front of a 16-bit SRAM.
// Read hits are served combinationally in IDLE; read misses and all writes
// go to the SRAM as two half-word accesses of SRAM_WAIT cycles each.
// Write-through, no-write-allocate.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mem           MEM-stage request channel (slave side)
//   SRAMaddress   SRAM half-word address (holds its last value when idle)
//   SRAMWEn       SRAM write enable, active low
//   SRAMOE        SRAM output enable, active low
//   SRAMdata      SRAM data bus, driven only in write states
//   state_dbg     current FSM state
module sram_cache_ctrl #(
    parameter int SRAM_WAIT = 2,
    parameter int LINES     = 64
) (
    input  logic                clk,
    input  logic                rst,
    sram_cache_ctrl_if.slave    mem,
    output logic [17:0]         SRAMaddress,
    output logic                SRAMWEn,
    output logic                SRAMOE,
    inout  wire  [15:0]         SRAMdata,
    output logic [2:0]          state_dbg
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 14 - IDX_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_n;

    logic [3:0]  wait_cnt;
    logic [31:0] fill;
    logic        is_read;     // current transaction is a read miss
    logic [13:0] req_wi;      // word index latched when leaving IDLE
    logic [17:0] sram_addr;
    logic        drive;
    logic [15:0] drive_val;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    wire [13:0]      wi      = mem.address[15:2];
    wire [IDX_W-1:0] idx     = wi[IDX_W-1:0];
    wire [TAG_W-1:0] tag_in  = wi[13:IDX_W];
    wire [IDX_W-1:0] req_idx = req_wi[IDX_W-1:0];
    wire [TAG_W-1:0] req_tag = req_wi[13:IDX_W];

    wire hit     = valid[idx] && (tag_mem[idx] == tag_in);
    wire req_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    wire last    = (wait_cnt == 4'(SRAM_WAIT - 1));

    assign SRAMaddress = sram_addr;
    assign SRAMdata    = drive ? drive_val : 16'hzzzz;
    assign state_dbg   = state;

    always_comb begin
        state_n            = state;
        mem.readData       = 32'h0;
        mem.SRAM_NOT_READY = 1'b0;
        SRAMWEn            = 1'b1;
        SRAMOE             = 1'b1;
        drive              = 1'b0;
        drive_val          = 16'h0;
        case (state)
            IDLE: begin
                if (mem.MEM_W_EN) begin
                    mem.SRAM_NOT_READY = 1'b1;
                    state_n            = WR_LO;
                end else if (mem.MEM_R_EN) begin
                    if (hit) begin
                        mem.readData = data_mem[idx];
                    end else begin
                        mem.SRAM_NOT_READY = 1'b1;
                        state_n            = RD_LO;
                    end
                end
            end
            RD_LO, RD_HI: begin
                SRAMOE             = 1'b0;
                mem.SRAM_NOT_READY = 1'b1;
                if (last) state_n = (state == RD_LO) ? RD_HI : DONE;
            end
            WR_LO, WR_HI: begin
                SRAMWEn            = 1'b0;
                mem.SRAM_NOT_READY = 1'b1;
                drive              = 1'b1;
                drive_val          = (state == WR_LO) ? mem.writeData[15:0]
                                                      : mem.writeData[31:16];
                if (last) state_n = (state == WR_LO) ? WR_HI : DONE;
            end
            DONE: begin
                // The request is still asserted here; going straight back to
                // IDLE means it is only looked at again on the next cycle.
                mem.readData = is_read ? fill : 32'h0;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            fill      <= 32'h0;
            is_read   <= 1'b0;
            req_wi    <= 14'h0;
            sram_addr <= 18'h0;
            valid     <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    wait_cnt <= 4'd0;
                    if (state_n != IDLE) begin
                        req_wi    <= wi;
                        sram_addr <= {3'b0, wi, 1'b0};
                        is_read   <= (state_n == RD_LO);
                    end
                end
                RD_LO, RD_HI, WR_LO, WR_HI: begin
                    wait_cnt <= last ? 4'd0 : wait_cnt + 4'd1;
                    if (last) begin
                        if (state == RD_LO) fill[15:0]  <= SRAMdata;
                        if (state == RD_HI) fill[31:16] <= SRAMdata;
                        if (state == RD_LO || state == WR_LO)
                            sram_addr <= {3'b0, req_wi, 1'b1};
                    end
                end
                DONE: begin
                    if (is_read) valid[req_idx] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage has no reset; validity is carried only by 'valid'.
    // Gating on !rst keeps an abort from updating any line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == DONE && is_read) begin
                tag_mem[req_idx]  <= req_tag;
                data_mem[req_idx] <= fill;
            end else if (state == WR_HI && last && req_hit) begin
                data_mem[req_idx] <= mem.writeData;
            end
        end
    end
endmodule
